// File: rtl/uart_tx_feeder_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_pkg
// Shared definitions for the UART transmit stack.
//   UART_DBIT      default data bits per byte, same as the transmitter
//   UART_ADDR_W    default byte-buffer address width (2**UART_ADDR_W entries)
//   feeder_state_t launch FSM states: IDLE (can launch), WAIT (byte on the line)
// ---------------------------------------------------------------------------
package uart_tx_feeder_pkg;

  localparam int UART_DBIT   = 8;
  localparam int UART_ADDR_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_if
// Bundles every non-clock, non-reset signal of the transmit feeder.
//   wr, w_data      byte write strobe and data from the game logic
//   full, empty     buffer occupancy flags
//   count           buffer occupancy, 0..2**ADDR_W
//   overflow        one-cycle pulse when a write is dropped
//   tx_start, din   launch pulse and byte toward the UART transmitter
//   tx_done_tick    completion pulse back from the transmitter
//   busy            a launched byte has not completed yet
// Modports:
//   slave  - the feeder itself
//   master - its surroundings (game logic writer plus the transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_feeder_if #(
  parameter int DBIT   = uart_tx_feeder_pkg::UART_DBIT,
  parameter int ADDR_W = uart_tx_feeder_pkg::UART_ADDR_W
);

  logic              wr;
  logic [DBIT-1:0]   w_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_start;
  logic [DBIT-1:0]   din;
  logic              tx_done_tick;
  logic              busy;

  modport master (
    output wr, w_data, tx_done_tick,
    input  full, empty, count, overflow, tx_start, din, busy
  );

  modport slave (
    input  wr, w_data, tx_done_tick,
    output full, empty, count, overflow, tx_start, din, busy
  );

endinterface

// File: rtl/uart_tx_feeder_fifo_circ.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_fifo_circ
// Generic circular FIFO (fifo_circ) used as the feeder's byte buffer.
//   clk, reset   clock and asynchronous active-high reset
//   wr, w_data   write strobe and data; accepted if not full or if a read
//                happens in the same cycle
//   rd           read strobe; ignored while empty
//   r_data       head entry, mem[rd_ptr]
//   full, empty  derived from the registered occupancy count
//   count        occupancy, 0..2**ADDR_W
// Memory contents are deliberately not reset.
// ---------------------------------------------------------------------------
module uart_tx_feeder_fifo_circ
  import uart_tx_feeder_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              do_wr;
  logic              do_rd;

  assign full   = (count_q == FULL_COUNT);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign r_data = mem[rd_ptr];

  // A read frees a slot at the same edge, so a write into a full buffer
  // is still safe when it coincides with a read.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Storage array: written only, never cleared, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= w_data;
    end
  end

  // Pointers wrap naturally at 2**ADDR_W; the count is kept as its own
  // register so full and empty are clean decodes rather than pointer math.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte buffer and launch controller sitting in front of the UART transmitter.
// Bytes written at any rate are queued; one tx_start pulse is issued per byte
// with din holding that byte, and the next launch waits for tx_done_tick.
//   clk    system clock
//   reset  asynchronous active-high reset (flushes the buffer, FSM to IDLE)
//   bus    uart_tx_feeder_if.slave: wr, w_data, full, empty, count, overflow,
//          tx_start, din, tx_done_tick, busy
// ---------------------------------------------------------------------------
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  bus
);

  feeder_state_t   state;
  logic            tx_start_q;
  logic            busy_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic [DBIT-1:0] fifo_head;
  logic            have_byte_next;

  // The launch pulse doubles as the pop: the transmitter samples din on the
  // same edge that advances the read pointer.
  uart_tx_feeder_fifo_circ #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_fifo_circ (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.wr),
    .w_data (bus.w_data),
    .rd     (tx_start_q),
    .r_data (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Only used on edges where no pop happens, so the buffer is non-empty next
  // cycle exactly when it already holds a byte or a write is being accepted.
  assign have_byte_next = !fifo_empty || (bus.wr && !fifo_full);

  // Launch FSM with registered outputs. tx_start_q is kept equal to
  // (state == IDLE && buffer non-empty) by computing next-cycle occupancy,
  // which gives a launch one cycle after a write into an empty buffer and one
  // cycle after tx_done_tick when bytes are waiting. A tx_done_tick seen in
  // IDLE has nothing to complete and is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_start_q) begin
            state      <= WAIT;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            tx_start_q <= have_byte_next;
          end
        end
        WAIT: begin
          if (bus.tx_done_tick) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            tx_start_q <= have_byte_next;
          end
        end
        default: begin
          state      <= IDLE;
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // A write into a full buffer is dropped unless the launch frees a slot in
  // the same cycle; the drop is flagged in the cycle it happens.
  assign bus.overflow = bus.wr && fifo_full && !tx_start_q;

  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.din      = fifo_head;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder: a table of single-cycle vectors followed
// by hand-written sequences for multi-cycle behaviour (spaced launches,
// fill/overflow/drain, reset while busy).
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

  uart_tx_feeder #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       wr;
    logic [7:0] w_data;
    logic       done;
    logic       exp_start;
    logic [7:0] exp_din;
    logic       exp_busy;
    logic       exp_empty;
    logic       exp_full;
    logic [4:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  localparam int NVEC = 18;

  vec_t       vecs [NVEC];
  int         compared   = 0;
  int         mismatched = 0;
  int         n_launch;
  int         last_launch;
  int         last_done;
  int         done_due;
  logic       done_now;
  logic       wr_now;
  logic       waiting;
  logic [7:0] data_now;
  logic [7:0] exp_a [3] = '{8'h01, 8'h02, 8'h03};
  logic [7:0] exp_q [$];

  // One comparison: counts it, and reports it when the values differ.
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the active edge, then let the
  // combinational outputs settle before anything is sampled.
  task automatic apply_stimulus(input logic wr, input logic [7:0] d, input logic done);
    @(posedge clk);
    #1;
    bus.wr           = wr;
    bus.w_data       = d;
    bus.tx_done_tick = done;
    #1;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    compare($sformatf("vec%0d tx_start", idx), 32'(bus.tx_start), 32'(v.exp_start));
    if (v.exp_start) begin
      compare($sformatf("vec%0d din", idx), 32'(bus.din), 32'(v.exp_din));
    end
    compare($sformatf("vec%0d busy", idx),     32'(bus.busy),     32'(v.exp_busy));
    compare($sformatf("vec%0d empty", idx),    32'(bus.empty),    32'(v.exp_empty));
    compare($sformatf("vec%0d full", idx),     32'(bus.full),     32'(v.exp_full));
    compare($sformatf("vec%0d count", idx),    32'(bus.count),    32'(v.exp_count));
    compare($sformatf("vec%0d overflow", idx), 32'(bus.overflow), 32'(v.exp_ovf));
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic done,
                              input logic st, input logic [7:0] din, input logic busy,
                              input logic empty, input logic [4:0] cnt);
    vec_t v;
    v.wr        = wr;
    v.w_data    = d;
    v.done      = done;
    v.exp_start = st;
    v.exp_din   = din;
    v.exp_busy  = busy;
    v.exp_empty = empty;
    v.exp_full  = 1'b0;
    v.exp_count = cnt;
    v.exp_ovf   = 1'b0;
    return v;
  endfunction

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //                wr    data   done  start din    busy  empty cnt
    vecs[0]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // idle after reset
    vecs[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // spurious done
    vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // nothing changed
    vecs[3]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // write A5
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd1); // launch A5
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0); // busy, empty
    vecs[6]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0); // queue 3C
    vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1); // done
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 5'd1); // launch 3C
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0); // done
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // idle empty
    vecs[11] = mk(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // write 11
    vecs[12] = mk(1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 5'd1); // write 22 during pop
    vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1); // count held, done
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 5'd1); // launch 22
    vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0);
    vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0); // done
    vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0); // idle again

    bus.wr           = 1'b0;
    bus.w_data       = 8'h00;
    bus.tx_done_tick = 1'b0;
    reset            = 1'b1;
    #1;
    compare("reset tx_start", 32'(bus.tx_start), 32'd0);
    compare("reset busy",     32'(bus.busy),     32'd0);
    compare("reset empty",    32'(bus.empty),    32'd1);
    compare("reset full",     32'(bus.full),     32'd0);
    compare("reset count",    32'(bus.count),    32'd0);
    compare("reset overflow", 32'(bus.overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].w_data, vecs[i].done);
      check_output(i, vecs[i]);
    end

    // Three bytes back to back, each completion 50 cycles after its launch.
    $display("[TB] spaced launches");
    n_launch    = 0;
    last_done   = -1000;
    done_due    = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      done_now = (cyc == done_due);
      apply_stimulus(cyc < 3, 8'(cyc + 1), done_now);
      if (done_now) last_done = cyc;
      if (bus.tx_start) begin
        if (n_launch < 3) begin
          compare("seqA din", 32'(bus.din), 32'(exp_a[n_launch]));
          if (n_launch > 0) compare("seqA launch cycle", 32'(cyc), 32'(last_done + 1));
        end else begin
          compare("seqA extra tx_start", 32'd1, 32'd0);
        end
        n_launch++;
        done_due = cyc + 50;
      end
    end
    compare("seqA launches", 32'(n_launch), 32'd3);

    // Eighteen writes with completion withheld: the 17th byte fills the
    // buffer and the 18th is dropped. A write in the launch cycle while full
    // is then accepted. Drain order must be 40..50 then 60.
    $display("[TB] fill, overflow and drain");
    n_launch    = 0;
    last_launch = -100;
    waiting     = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      wr_now   = (cyc < 18) || (cyc == 21);
      data_now = (cyc == 21) ? 8'h60 : 8'(8'h40 + cyc);
      done_now = (cyc >= 20) && waiting && (cyc >= last_launch + 2);
      apply_stimulus(wr_now, data_now, done_now);
      if (done_now) waiting = 1'b0;
      if (wr_now && cyc != 17) exp_q.push_back(data_now);
      compare($sformatf("seqB overflow c%0d", cyc), 32'(bus.overflow), 32'(cyc == 17));
      if (cyc == 16) begin
        compare("seqB full c16",  32'(bus.full),  32'd0);
        compare("seqB count c16", 32'(bus.count), 32'd15);
      end
      if (cyc == 17) begin
        compare("seqB full c17",  32'(bus.full),  32'd1);
        compare("seqB count c17", 32'(bus.count), 32'd16);
      end
      if (cyc == 21) begin
        compare("seqB tx_start while full", 32'(bus.tx_start), 32'd1);
        compare("seqB full at pop",         32'(bus.full),     32'd1);
      end
      if (cyc == 22) begin
        compare("seqB count after pop+write", 32'(bus.count), 32'd16);
        compare("seqB busy after pop",        32'(bus.busy),  32'd1);
      end
      if (bus.tx_start) begin
        if (exp_q.size() == 0) begin
          compare("seqB extra tx_start", 32'd1, 32'd0);
        end else begin
          compare("seqB din", 32'(bus.din), 32'(exp_q.pop_front()));
        end
        n_launch++;
        last_launch = cyc;
        waiting     = 1'b1;
      end
    end
    compare("seqB launches",   32'(n_launch),     32'd18);
    compare("seqB leftover",   32'(exp_q.size()), 32'd0);
    compare("seqB empty end",  32'(bus.empty),    32'd1);
    compare("seqB busy end",   32'(bus.busy),     32'd0);

    // Reset while a byte is in flight and five more are queued.
    $display("[TB] reset while busy");
    for (int cyc = 0; cyc < 6; cyc++) begin
      apply_stimulus(1'b1, 8'(8'h90 + cyc), 1'b0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    compare("seqC busy before reset",  32'(bus.busy),  32'd1);
    compare("seqC count before reset", 32'(bus.count), 32'd5);
    reset = 1'b1;
    #1;
    compare("seqC busy in reset",     32'(bus.busy),     32'd0);
    compare("seqC count in reset",    32'(bus.count),    32'd0);
    compare("seqC empty in reset",    32'(bus.empty),    32'd1);
    compare("seqC tx_start in reset", 32'(bus.tx_start), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0);
      compare($sformatf("seqC no launch c%0d", cyc), 32'(bus.tx_start), 32'd0);
    end
    apply_stimulus(1'b1, 8'h77, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    compare("seqC launch after write", 32'(bus.tx_start), 32'd1);
    compare("seqC din after write",    32'(bus.din),      32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
